// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 constants for the exception unit.
// Holds register addresses, ExcCode values, exception-vector bit indices,
// Status/Cause field positions and the Status field struct.
package cp0_pkg;

  // CP0 register addresses (MFC0/MTC0 rd field)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam int unsigned EXC_W = 5;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'h00;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'h0A;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'h0C;

  // Bit indices within the M-stage exception vector
  localparam int unsigned EV_W         = 8;
  localparam int unsigned EV_INST_ADEL = 0;
  localparam int unsigned EV_RI        = 1;
  localparam int unsigned EV_OV        = 2;
  localparam int unsigned EV_SYS       = 3;
  localparam int unsigned EV_BRK       = 4;
  localparam int unsigned EV_ADEL      = 5;
  localparam int unsigned EV_ADES      = 6;
  localparam int unsigned EV_ERET      = 7;

  // Status / Cause field positions
  localparam int unsigned ST_IE      = 0;
  localparam int unsigned ST_EXL     = 1;
  localparam int unsigned ST_IM_LSB  = 8;
  localparam int unsigned CA_EXC_LSB = 2;
  localparam int unsigned CA_IP_LSB  = 8;
  localparam int unsigned CA_TI      = 30;
  localparam int unsigned CA_BD      = 31;
  localparam int unsigned IP_W       = 8;

  // Status reset value: only BEV set
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  // Writable Status state
  typedef struct packed {
    logic [IP_W-1:0] im;
    logic            exl;
    logic            ie;
  } status_t;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// cp0_exc_arbiter: combinational priority encoder for M-stage events.
// Ports:
//   valid_i     M-stage instruction valid
//   int_pend_i  qualified interrupt pending (highest priority)
//   exc_vec_i   {eret, ades, adel, brk, sys, ov, ri, inst_adel}
//   taken_o     an exception (not eret) is taken
//   exc_code_o  ExcCode of the winning exception, 0 otherwise
//   is_eret_o   eret wins (no exception pending)
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic             valid_i,
  input  logic             int_pend_i,
  input  logic [EV_W-1:0]  exc_vec_i,
  output logic             taken_o,
  output logic [EXC_W-1:0] exc_code_o,
  output logic             is_eret_o
);

  // Fixed priority: int, inst_adel, ri, ov, sys, brk, adel, ades, eret
  always_comb begin
    taken_o    = 1'b0;
    exc_code_o = EXC_INT;
    is_eret_o  = 1'b0;
    if (valid_i) begin
      taken_o = 1'b1;
      if (int_pend_i)                   exc_code_o = EXC_INT;
      else if (exc_vec_i[EV_INST_ADEL]) exc_code_o = EXC_ADEL;
      else if (exc_vec_i[EV_RI])        exc_code_o = EXC_RI;
      else if (exc_vec_i[EV_OV])        exc_code_o = EXC_OV;
      else if (exc_vec_i[EV_SYS])       exc_code_o = EXC_SYS;
      else if (exc_vec_i[EV_BRK])       exc_code_o = EXC_BP;
      else if (exc_vec_i[EV_ADEL])      exc_code_o = EXC_ADEL;
      else if (exc_vec_i[EV_ADES])      exc_code_o = EXC_ADES;
      else begin
        taken_o   = 1'b0;
        is_eret_o = exc_vec_i[EV_ERET];
      end
    end
  end

endmodule

// File: rtl/cp0_except_unit.sv
// cp0_except_unit: MIPS-style CP0 register file and exception control.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   ext_int                     level hardware interrupts -> Cause.IP[2+:N]
//   valid_m, pc_m, is_ds_m      M-stage instruction info
//   exc_vec_m, badaddr_m        M-stage exception flags and data address
//   cp0_we/waddr/wdata          MTC0 write port
//   cp0_raddr/rdata             MFC0 combinational read port
//   flush, newpc, exc_code      same-cycle redirect outputs
//   timer_int                   sticky Count==Compare flag
// Optional feature: define CP0_TIMER_EN to make Count tick every second clk
// and raise the timer interrupt on Count==Compare.
module cp0_except_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned ADDR_W     = 32
)(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic                  valid_m,
  input  logic [ADDR_W-1:0]     pc_m,
  input  logic                  is_ds_m,
  input  logic [7:0]            exc_vec_m,
  input  logic [ADDR_W-1:0]     badaddr_m,
  input  logic                  cp0_we,
  input  logic [4:0]            cp0_waddr,
  input  logic [31:0]           cp0_wdata,
  input  logic [4:0]            cp0_raddr,
  output logic [31:0]           cp0_rdata,
  output logic                  flush,
  output logic [ADDR_W-1:0]     newpc,
  output logic [4:0]            exc_code,
  output logic                  timer_int
);

  status_t               st_q, st_d;
  logic                  bd_q, bd_d;
  logic [EXC_W-1:0]      excode_q, excode_d;
  logic [NUM_HW_INT-1:0] ip_hw_q;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [ADDR_W-1:0]     epc_q, epc_d, badva_q, badva_d;
  logic [31:0]           count_q, count_d, compare_q, compare_d;
  logic                  ti;
  logic [IP_W-1:0]       ip;
  logic                  int_pend, exc_taken, is_eret, exc_upd;
  logic [EXC_W-1:0]      arb_code;
  logic                  wr_cnt, wr_cmp;
  logic [31:0]           status_rd, cause_rd;

`ifdef CP0_TIMER_EN
  logic div_q, ti_q;
`endif

  // Assemble Cause.IP: software bits, hardware lines, timer on IP[7]
  always_comb begin
    ip                    = '0;
    ip[1:0]               = ip_sw_q;
    ip[2 +: NUM_HW_INT]   = ip_hw_q;
    ip[7]                 = ip[7] | ti;
  end

  assign int_pend = valid_m & st_q.ie & ~st_q.exl & (|(ip & st_q.im));

  cp0_exc_arbiter u_arb (
    .valid_i    (valid_m),
    .int_pend_i (int_pend),
    .exc_vec_i  (exc_vec_m),
    .taken_o    (exc_taken),
    .exc_code_o (arb_code),
    .is_eret_o  (is_eret)
  );

  assign exc_upd = exc_taken | is_eret;
  assign wr_cnt  = cp0_we & (cp0_waddr == CP0_COUNT);
  assign wr_cmp  = cp0_we & (cp0_waddr == CP0_COMPARE);

  // Next-state: timer tick, then MTC0, then exception/eret updates
  always_comb begin
    st_d      = st_q;
    bd_d      = bd_q;
    excode_d  = excode_q;
    ip_sw_d   = ip_sw_q;
    epc_d     = epc_q;
    badva_d   = badva_q;
    count_d   = count_q;
    compare_d = compare_q;

`ifdef CP0_TIMER_EN
    if (div_q) count_d = count_q + 32'd1;
`endif

    if (wr_cnt) count_d   = cp0_wdata;
    if (wr_cmp) compare_d = cp0_wdata;
    // Status/Cause/EPC writes lose to a same-cycle exception or eret
    if (cp0_we && !exc_upd) begin
      case (cp0_waddr)
        CP0_STATUS: begin
          st_d.im  = cp0_wdata[ST_IM_LSB +: IP_W];
          st_d.exl = cp0_wdata[ST_EXL];
          st_d.ie  = cp0_wdata[ST_IE];
        end
        CP0_CAUSE: ip_sw_d = cp0_wdata[CA_IP_LSB +: 2];
        CP0_EPC:   epc_d   = ADDR_W'(cp0_wdata);
        default: ;
      endcase
    end

    if (exc_taken) begin
      st_d.exl = 1'b1;
      excode_d = arb_code;
      // Nested exceptions keep the original return point
      if (!st_q.exl) begin
        bd_d  = is_ds_m;
        epc_d = is_ds_m ? (pc_m - ADDR_W'(4)) : pc_m;
      end
      if (!int_pend && exc_vec_m[EV_INST_ADEL])
        badva_d = pc_m;
      else if (arb_code == EXC_ADEL || arb_code == EXC_ADES)
        badva_d = badaddr_m;
    end else if (is_eret) begin
      st_d.exl = 1'b0;
    end
  end

  // CP0 state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q      <= '0;
      bd_q      <= 1'b0;
      excode_q  <= '0;
      ip_hw_q   <= '0;
      ip_sw_q   <= '0;
      epc_q     <= '0;
      badva_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      st_q      <= st_d;
      bd_q      <= bd_d;
      excode_q  <= excode_d;
      ip_hw_q   <= ext_int;
      ip_sw_q   <= ip_sw_d;
      epc_q     <= epc_d;
      badva_q   <= badva_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

`ifdef CP0_TIMER_EN
  // Divide-by-two tick and sticky Count==Compare flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= 1'b0;
      ti_q  <= 1'b0;
    end else begin
      div_q <= wr_cnt ? 1'b0 : ~div_q;
      if (wr_cmp)
        ti_q <= 1'b0;
      else if (count_q == compare_q)
        ti_q <= 1'b1;
    end
  end
  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  // Read-side views of Status and Cause
  always_comb begin
    status_rd                        = STATUS_RST;
    status_rd[ST_IM_LSB +: IP_W]     = st_q.im;
    status_rd[ST_EXL]                = st_q.exl;
    status_rd[ST_IE]                 = st_q.ie;
    cause_rd                         = '0;
    cause_rd[CA_BD]                  = bd_q;
    cause_rd[CA_TI]                  = ti;
    cause_rd[CA_IP_LSB +: IP_W]      = ip;
    cause_rd[CA_EXC_LSB +: EXC_W]    = excode_q;
  end

  // MFC0 read mux, pre-edge values only
  always_comb begin
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = 32'(badva_q);
      CP0_COUNT:    cp0_rdata = count_q;
      CP0_COMPARE:  cp0_rdata = compare_q;
      CP0_STATUS:   cp0_rdata = status_rd;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = 32'(epc_q);
      default:      cp0_rdata = '0;
    endcase
  end

  // Redirect outputs held quiet during reset
  always_comb begin
    newpc = '0;
    if (resetn) begin
      if (is_eret)        newpc = epc_q;
      else if (exc_taken) newpc = ADDR_W'(EXC_VECTOR);
    end
  end

  assign flush     = resetn & exc_upd;
  assign exc_code  = (resetn & exc_taken) ? arb_code : '0;
  assign timer_int = ti;

endmodule

// File: tb/tb_cp0_except_unit.sv
// Directed self-checking bench for cp0_except_unit.
module tb_cp0_except_unit;

  logic        clk;
  logic        resetn;
  logic [5:0]  ext_int;
  logic        valid_m;
  logic [31:0] pc_m;
  logic        is_ds_m;
  logic [7:0]  exc_vec_m;
  logic [31:0] badaddr_m;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic [31:0] newpc;
  logic [4:0]  exc_code;
  logic        timer_int;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] R_BADVA = 5'd8,  R_COUNT = 5'd9, R_CMP = 5'd11,
                         R_STAT  = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;
  localparam logic [7:0] V_IADEL = 8'h01, V_RI = 8'h02, V_OV = 8'h04, V_SYS = 8'h08,
                         V_BRK = 8'h10, V_ADEL = 8'h20, V_ADES = 8'h40, V_ERET = 8'h80;
  localparam logic [31:0] VEC = 32'hBFC00380;

  cp0_except_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .ext_int   (ext_int),
    .valid_m   (valid_m),
    .pc_m      (pc_m),
    .is_ds_m   (is_ds_m),
    .exc_vec_m (exc_vec_m),
    .badaddr_m (badaddr_m),
    .cp0_we    (cp0_we),
    .cp0_waddr (cp0_waddr),
    .cp0_wdata (cp0_wdata),
    .cp0_raddr (cp0_raddr),
    .cp0_rdata (cp0_rdata),
    .flush     (flush),
    .newpc     (newpc),
    .exc_code  (exc_code),
    .timer_int (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_raddr = a;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    @(negedge clk);
    cp0_we = 1'b0;
  endtask

  // Present an M-stage instruction at a falling edge, outputs settled after #1
  task automatic instr(input logic [7:0] v, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
    @(negedge clk);
    valid_m = 1'b1; exc_vec_m = v; pc_m = pc; is_ds_m = ds; badaddr_m = bad;
    #1;
  endtask

  // Let the next rising edge capture the instruction
  task automatic commit();
    @(negedge clk);
    valid_m = 1'b0; exc_vec_m = '0; cp0_we = 1'b0;
  endtask

  // Withdraw the instruction before the rising edge
  task automatic cancel();
    valid_m = 1'b0; exc_vec_m = '0;
  endtask

  task automatic do_eret(input string tag, input logic [31:0] exp_pc);
    instr(V_ERET, 32'h8000_0F00, 1'b0, 32'h0);
    check({tag, "_newpc"}, newpc, exp_pc);
    commit();
  endtask

  logic [7:0] pv [7];
  logic [4:0] pc_exp [7];

  initial begin
    resetn = 1'b0; ext_int = '0; valid_m = 1'b1; pc_m = 32'h8000_1000; is_ds_m = 1'b0;
    exc_vec_m = V_RI; badaddr_m = '0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0;
    cp0_raddr = '0;
    #1;
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_newpc", newpc, 32'h0);
    check("rst_code", 32'(exc_code), 32'h0);
    check("rst_ti", 32'(timer_int), 32'h0);
    chk_reg("rst_status", R_STAT, 32'h0040_0000);
    chk_reg("rst_cause", R_CAUSE, 32'h0);
    repeat (2) @(negedge clk);
    valid_m = 1'b0; exc_vec_m = '0;
    resetn = 1'b1;

    // RI, not in delay slot
    instr(V_RI, 32'h8000_1000, 1'b0, 32'h0);
    check("ri_flush", 32'(flush), 32'h1);
    check("ri_newpc", newpc, VEC);
    check("ri_code", 32'(exc_code), 32'h0A);
    commit();
    chk_reg("ri_epc", R_EPC, 32'h8000_1000);
    chk_reg("ri_status", R_STAT, 32'h0040_0002);
    chk_reg("ri_cause", R_CAUSE, 32'h0000_0028);
    chk_reg("ri_badva", R_BADVA, 32'h0);

    // eret with a simultaneous MTC0 Status that must be discarded
    instr(V_ERET, 32'h8000_1100, 1'b0, 32'h0);
    cp0_we = 1'b1; cp0_waddr = R_STAT; cp0_wdata = 32'h1;
    #1;
    check("eret_flush", 32'(flush), 32'h1);
    check("eret_newpc", newpc, 32'h8000_1000);
    check("eret_code", 32'(exc_code), 32'h0);
    commit();
    chk_reg("eret_status", R_STAT, 32'h0040_0000);

    // SYS in a delay slot
    instr(V_SYS, 32'h8000_2004, 1'b1, 32'h0);
    check("sys_code", 32'(exc_code), 32'h08);
    commit();
    chk_reg("sys_epc", R_EPC, 32'h8000_2000);
    chk_reg("sys_cause", R_CAUSE, 32'h8000_0020);
    do_eret("sys_eret", 32'h8000_2000);

    // Nested exception while EXL=1 keeps EPC and BD
    instr(V_BRK, 32'h8000_3000, 1'b0, 32'h0);
    check("brk_code", 32'(exc_code), 32'h09);
    commit();
    instr(V_OV, 32'h8000_4004, 1'b1, 32'h0);
    check("nest_flush", 32'(flush), 32'h1);
    check("nest_code", 32'(exc_code), 32'h0C);
    commit();
    chk_reg("nest_epc", R_EPC, 32'h8000_3000);
    chk_reg("nest_cause", R_CAUSE, 32'h0000_0030);
    chk_reg("nest_status", R_STAT, 32'h0040_0002);
    do_eret("nest_eret", 32'h8000_3000);

    // Address errors and BadVAddr capture
    instr(V_ADEL, 32'h8000_5000, 1'b0, 32'h8000_0003);
    check("adel_code", 32'(exc_code), 32'h04);
    commit();
    chk_reg("adel_badva", R_BADVA, 32'h8000_0003);
    do_eret("adel_eret", 32'h8000_5000);
    instr(V_IADEL | V_ADEL, 32'h8000_6000, 1'b0, 32'h8000_0003);
    check("iadel_code", 32'(exc_code), 32'h04);
    commit();
    chk_reg("iadel_badva", R_BADVA, 32'h8000_6000);
    do_eret("iadel_eret", 32'h8000_6000);
    instr(V_ADES, 32'h8000_7000, 1'b0, 32'h8000_0007);
    check("ades_code", 32'(exc_code), 32'h05);
    commit();
    chk_reg("ades_badva", R_BADVA, 32'h8000_0007);
    do_eret("ades_eret", 32'h8000_7000);
    instr(V_BRK, 32'h8000_8000, 1'b0, 32'h1234_5678);
    commit();
    chk_reg("brk_badva", R_BADVA, 32'h8000_0007);
    do_eret("brk_eret", 32'h8000_8000);

    // Priority between simultaneous exceptions, withdrawn before the edge
    pv[0] = V_RI | V_OV;     pc_exp[0] = 5'h0A;
    pv[1] = V_OV | V_SYS;    pc_exp[1] = 5'h0C;
    pv[2] = V_SYS | V_BRK;   pc_exp[2] = 5'h08;
    pv[3] = V_BRK | V_ADEL;  pc_exp[3] = 5'h09;
    pv[4] = V_ADEL | V_ADES; pc_exp[4] = 5'h04;
    pv[5] = V_ADES | V_ERET; pc_exp[5] = 5'h05;
    pv[6] = V_IADEL | V_RI;  pc_exp[6] = 5'h04;
    for (int i = 0; i < 7; i++) begin
      instr(pv[i], 32'h8000_A000, 1'b0, 32'h0);
      check($sformatf("prio%0d_code", i), 32'(exc_code), 32'(pc_exp[i]));
      check($sformatf("prio%0d_newpc", i), newpc, VEC);
      cancel();
    end
    @(negedge clk);
    valid_m = 1'b0; exc_vec_m = V_ERET | V_RI; #1;
    check("inval_flush", 32'(flush), 32'h0);
    check("inval_newpc", newpc, 32'h0);
    cancel();

    // Hardware interrupt beats a simultaneous overflow
    mtc0(R_STAT, 32'h0000_FF01);
    chk_reg("int_status", R_STAT, 32'h0040_FF01);
    @(negedge clk); ext_int = 6'h01;
    @(negedge clk);
    chk_reg("int_cause_ip", R_CAUSE, 32'h0000_0424);
    instr(V_OV, 32'h8000_9000, 1'b0, 32'h0);
    check("int_flush", 32'(flush), 32'h1);
    check("int_code", 32'(exc_code), 32'h00);
    check("int_newpc", newpc, VEC);
    commit();
    chk_reg("int_status2", R_STAT, 32'h0040_FF03);
    chk_reg("int_cause2", R_CAUSE, 32'h0000_0400);
    chk_reg("int_epc", R_EPC, 32'h8000_9000);
    instr(8'h00, 32'h8000_9100, 1'b0, 32'h0);
    check("int_exl_mask", 32'(flush), 32'h0);
    cancel();
    ext_int = 6'h00;
    do_eret("int_eret", 32'h8000_9000);
    chk_reg("int_status3", R_STAT, 32'h0040_FF01);

    // Software interrupt and masking
    mtc0(R_CAUSE, 32'h0000_0300);
    chk_reg("sw_cause", R_CAUSE, 32'h0000_0300);
    instr(8'h00, 32'h8000_B000, 1'b0, 32'h0);
    check("sw_flush", 32'(flush), 32'h1);
    check("sw_code", 32'(exc_code), 32'h00);
    cancel();
    mtc0(R_STAT, 32'h0000_FC01);
    instr(8'h00, 32'h8000_B000, 1'b0, 32'h0);
    check("sw_im_mask", 32'(flush), 32'h0);
    cancel();
    mtc0(R_CAUSE, 32'h0);
    mtc0(R_STAT, 32'h0000_FF00);
    @(negedge clk); ext_int = 6'h01;
    instr(8'h00, 32'h8000_C000, 1'b0, 32'h0);
    check("ie_mask", 32'(flush), 32'h0);
    cancel();
    ext_int = 6'h00;
    mtc0(R_STAT, 32'h0);

    // Unimplemented addresses and read-only BadVAddr
    chk_reg("rd_unimp0", 5'd0, 32'h0);
    chk_reg("rd_unimp15", 5'd15, 32'h0);
    mtc0(R_BADVA, 32'h1234_5678);
    chk_reg("badva_ro", R_BADVA, 32'h8000_0007);

`ifdef CP0_TIMER_EN
    mtc0(R_CMP, 32'd10);
    mtc0(R_COUNT, 32'd0);
    repeat (10) @(negedge clk);
    chk_reg("tmr_count5", R_COUNT, 32'd5);
    check("tmr_ti_early", 32'(timer_int), 32'h0);
    begin
      int n = 0;
      while (!timer_int && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("tmr_ti_set", 32'(timer_int), 32'h1);
    chk_reg("tmr_count10", R_COUNT, 32'd10);
    cp0_raddr = R_CAUSE; #1;
    check("tmr_cause_ti", cp0_rdata & 32'h4000_8000, 32'h4000_8000);
    repeat (4) @(negedge clk);
    check("tmr_sticky", 32'(timer_int), 32'h1);
    mtc0(R_CMP, 32'd100);
    check("tmr_clr", 32'(timer_int), 32'h0);
`else
    mtc0(R_CMP, 32'd10);
    mtc0(R_COUNT, 32'd5);
    repeat (6) @(negedge clk);
    chk_reg("cnt_store", R_COUNT, 32'd5);
    chk_reg("cmp_store", R_CMP, 32'd10);
    check("ti_off", 32'(timer_int), 32'h0);
`endif

    // Reset pulse mid-count
    mtc0(R_COUNT, 32'h0000_1234);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_reg("rst2_count", R_COUNT, 32'h0);
    chk_reg("rst2_status", R_STAT, 32'h0040_0000);
    check("rst2_ti", 32'(timer_int), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
